// File: rtl/disp_frame_pkg.sv
// Shared constants and types for the display frame transmitter.
// Holds the frame header, payload length, FSM state type, flags layout
// and the packed snapshot record whose field order is the payload order.
package disp_frame_pkg;

   localparam logic [7:0] FRAME_HDR   = 8'hA5;
   localparam int         PAYLOAD_LEN = 62;
   localparam int         CNT_W       = 6;
   localparam logic [CNT_W-1:0] PAYLOAD_LAST = CNT_W'(PAYLOAD_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      PAYLOAD,
      CHECKSUM
   } state_t;

   // Control flags byte: {4'b0, RegWrite, MemtoReg, Branch, MemWrite}
   typedef struct packed {
      logic [3:0] rsvd;
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
      logic       mem_write;
   } flags_t;

   // Field order matches transmit order: the most significant byte of the
   // flattened record is payload byte 0.
   typedef struct packed {
      logic [7:0]        led;
      logic [7:0]        seg;
      logic [7:0]        pc;
      logic [31:0]       instr;
      logic [7:0]        src_a;
      logic [7:0]        src_b;
      logic [7:0]        alu_result;
      logic [7:0]        result;
      logic [7:0]        write_data;
      logic [7:0]        read_data;
      flags_t            flags;
      logic [0:31][7:0]  regs;
      logic [63:0]       lcd_a;
      logic [63:0]       lcd_b;
   } snap_t;

   localparam int SNAP_BITS = $bits(snap_t);

   function automatic flags_t make_flags(input logic reg_write,
                                         input logic mem_to_reg,
                                         input logic branch,
                                         input logic mem_write);
      flags_t f;
      f            = '0;
      f.reg_write  = reg_write;
      f.mem_to_reg = mem_to_reg;
      f.branch     = branch;
      f.mem_write  = mem_write;
      return f;
   endfunction

endpackage

// File: rtl/disp_frame_if.sv
// Byte-stream handshake between the frame transmitter and the host sink.
interface disp_frame_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_sof;
   logic       tx_eof;

   modport master (output tx_data, output tx_valid, output tx_sof,
                   output tx_eof, input tx_ready);
   modport slave  (input tx_data, input tx_valid, input tx_sof,
                   input tx_eof, output tx_ready);
endinterface

// File: rtl/disp_frame_bytesel.sv
// Combinational payload byte selector: picks byte byte_idx (0..61) out of
// the snapshot record. Indices past the payload read as zero.
import disp_frame_pkg::*;

module disp_frame_bytesel (
   input  snap_t               snap,
   input  logic [CNT_W-1:0]    byte_idx,
   output logic [7:0]          byte_out
);

   logic [SNAP_BITS-1:0] flat;
   logic [7:0]           byte_tbl [0:(1<<CNT_W)-1];

   assign flat = snap;

   genvar gi;
   generate
      for (gi = 0; gi < (1 << CNT_W); gi++) begin : g_tbl
         if (gi < PAYLOAD_LEN) begin : g_byte
            assign byte_tbl[gi] = flat[SNAP_BITS-1-8*gi -: 8];
         end else begin : g_pad
            assign byte_tbl[gi] = 8'h00;
         end
      end
   endgenerate

   assign byte_out = byte_tbl[byte_idx];

endmodule

// File: rtl/disp_frame_tx.sv
// Display frame transmitter: on request, snapshots the datapath display
// values and streams a 64-byte frame (header, 62 payload bytes, XOR
// checksum) over a valid/ready byte interface. Requests that arrive while
// a frame is in flight collapse into one follow-on frame.
import disp_frame_pkg::*;

module disp_frame_tx #(
   parameter int NBITS_TOP   = 8,
   parameter int NREGS_TOP   = 32,
   parameter int NBITS_LCD   = 64,
   parameter int NBITS_INSTR = 32
) (
   input  logic                   clk_2,
   input  logic                   rst_n,
   input  logic                   frame_req,
   input  logic [NBITS_TOP-1:0]   LED,
   input  logic [NBITS_TOP-1:0]   SEG,
   input  logic [NBITS_TOP-1:0]   lcd_pc,
   input  logic [NBITS_INSTR-1:0] lcd_instruction,
   input  logic [NBITS_TOP-1:0]   lcd_SrcA,
   input  logic [NBITS_TOP-1:0]   lcd_SrcB,
   input  logic [NBITS_TOP-1:0]   lcd_ALUResult,
   input  logic [NBITS_TOP-1:0]   lcd_Result,
   input  logic [NBITS_TOP-1:0]   lcd_WriteData,
   input  logic [NBITS_TOP-1:0]   lcd_ReadData,
   input  logic                   lcd_MemWrite,
   input  logic                   lcd_Branch,
   input  logic                   lcd_MemtoReg,
   input  logic                   lcd_RegWrite,
   input  logic [NBITS_TOP-1:0]   lcd_registrador [0:NREGS_TOP-1],
   input  logic [NBITS_LCD-1:0]   lcd_a,
   input  logic [NBITS_LCD-1:0]   lcd_b,
   disp_frame_if.master           tx,
   output logic                   busy
);

   state_t             state_reg, state_next;
   snap_t              snap_reg, live_snap;
   logic [CNT_W-1:0]   cnt_reg;
   logic [7:0]         cksum_reg;
   logic               pending_reg;

   logic [0:NREGS_TOP-1][NBITS_TOP-1:0] live_regs;
   logic [7:0]         payload_byte;
   logic               take_snap;
   logic               payload_accept;
   logic [7:0]         data_c;
   logic               valid_c, sof_c, eof_c;

   genvar gi;
   generate
      for (gi = 0; gi < NREGS_TOP; gi++) begin : g_regs
         assign live_regs[gi] = lcd_registrador[gi];
      end
   endgenerate

   // Assemble the live input values into snapshot layout
   always_comb begin
      live_snap            = '0;
      live_snap.led        = LED;
      live_snap.seg        = SEG;
      live_snap.pc         = lcd_pc;
      live_snap.instr      = lcd_instruction;
      live_snap.src_a      = lcd_SrcA;
      live_snap.src_b      = lcd_SrcB;
      live_snap.alu_result = lcd_ALUResult;
      live_snap.result     = lcd_Result;
      live_snap.write_data = lcd_WriteData;
      live_snap.read_data  = lcd_ReadData;
      live_snap.flags      = make_flags(lcd_RegWrite, lcd_MemtoReg,
                                        lcd_Branch, lcd_MemWrite);
      live_snap.regs       = live_regs;
      live_snap.lcd_a      = lcd_a;
      live_snap.lcd_b      = lcd_b;
   end

   disp_frame_bytesel u_bytesel (
      .snap     (snap_reg),
      .byte_idx (cnt_reg),
      .byte_out (payload_byte)
   );

   // State register; reset aborts any frame in flight
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state and stream outputs; outputs depend only on registered
   // state so they stay stable while the sink stalls
   always_comb begin
      state_next = state_reg;
      take_snap  = 1'b0;
      data_c     = 8'h00;
      valid_c    = 1'b0;
      sof_c      = 1'b0;
      eof_c      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (frame_req) begin
               state_next = HEADER;
               take_snap  = 1'b1;
            end
         end
         HEADER: begin
            valid_c = 1'b1;
            sof_c   = 1'b1;
            data_c  = FRAME_HDR;
            if (tx.tx_ready) begin
               state_next = PAYLOAD;
            end
         end
         PAYLOAD: begin
            valid_c = 1'b1;
            data_c  = payload_byte;
            if (tx.tx_ready && (cnt_reg == PAYLOAD_LAST)) begin
               state_next = CHECKSUM;
            end
         end
         CHECKSUM: begin
            valid_c = 1'b1;
            eof_c   = 1'b1;
            data_c  = cksum_reg;
            if (tx.tx_ready) begin
               // A request in this very cycle still counts as pending
               if (pending_reg || frame_req) begin
                  state_next = HEADER;
                  take_snap  = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign payload_accept = (state_reg == PAYLOAD) && tx.tx_ready;

   // Snapshot, byte counter, running checksum and pending-request flag
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         snap_reg    <= '0;
         cnt_reg     <= '0;
         cksum_reg   <= 8'h00;
         pending_reg <= 1'b0;
      end else begin
         if (take_snap) begin
            snap_reg  <= live_snap;
            cnt_reg   <= '0;
            cksum_reg <= 8'h00;
         end else if (payload_accept) begin
            // Fold in only accepted bytes so stalls never double-count
            cksum_reg <= cksum_reg ^ payload_byte;
            if (cnt_reg != PAYLOAD_LAST) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end
         if (take_snap) begin
            pending_reg <= 1'b0;
         end else if (frame_req && (state_reg != IDLE)) begin
            pending_reg <= 1'b1;
         end
      end
   end

   assign tx.tx_data  = data_c;
   assign tx.tx_valid = valid_c;
   assign tx.tx_sof   = sof_c;
   assign tx.tx_eof   = eof_c;
   assign busy        = (state_reg != IDLE);

endmodule
